// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: bus widths,
// the nop word returned on idle/blocked fetches, FSM state encodings and
// the padding helper used when an image ends on a partial word.
package inst_mem_responder_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;  // InstAddrBus
  typedef logic [INST_W-1:0]      inst_t;       // InstBus

  // All-zero word decodes as a MIPS nop.
  localparam inst_t ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    IMR_HOLD = 2'b00,
    IMR_LOAD = 2'b01,
    IMR_RUN  = 2'b10
  } imr_state_e;

  // Left-justify the n newest bytes of the shift register (newest byte in
  // [7:0]) and fill the missing low bytes with 0x00.
  function automatic inst_t pad_word(input logic [23:0] sr, input logic [1:0] n);
    inst_t w;
    case (n)
      2'd1:    w = {sr[7:0],  24'h00_0000};
      2'd2:    w = {sr[15:0], 16'h0000};
      2'd3:    w = {sr[23:0], 8'h00};
      default: w = ZeroWord;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch port plus byte-stream loader port of the instruction-memory responder.
// With INST_ALIGN_CHECK_EN defined the bus also carries misalign_o.
interface inst_mem_responder_if #(
  parameter int AW    = 10,
  parameter int CNT_W = AW + 1
);
  import inst_mem_responder_pkg::*;

  // Fetch side
  logic       rom_ce_i;
  inst_addr_t rom_addr_i;
  inst_t      rom_data_o;
`ifdef INST_ALIGN_CHECK_EN
  logic       misalign_o;
`endif

  // Loader side
  logic             ld_start_i;
  logic             ld_valid_i;
  logic [7:0]       ld_byte_i;
  logic             ld_ready_o;
  logic             ld_done_i;
  logic             cpu_hold_o;
  logic [CNT_W-1:0] ld_count_o;
  logic             ld_err_o;

  modport slave (
`ifdef INST_ALIGN_CHECK_EN
    output misalign_o,
`endif
    input  rom_ce_i, rom_addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_done_i,
    output rom_data_o, ld_ready_o, cpu_hold_o, ld_count_o, ld_err_o
  );

  modport master (
`ifdef INST_ALIGN_CHECK_EN
    input  misalign_o,
`endif
    output rom_ce_i, rom_addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_done_i,
    input  rom_data_o, ld_ready_o, cpu_hold_o, ld_count_o, ld_err_o
  );

endinterface

// File: rtl/inst_mem_responder_ld_packer.sv
// Big-endian byte-to-word packer for the loader stream. Emits a one-cycle
// word strobe on the 4th byte, or on flush when a partial word is pending
// (missing low bytes padded with 0x00). A byte arriving with the flush is
// folded in before the partial word is emitted.
module inst_mem_responder_ld_packer
  import inst_mem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_byte_vld,
  input  logic [7:0] i_byte,
  input  logic       i_flush,
  output logic       o_word_vld,
  output inst_t      o_word
);

  logic [1:0]  r_idx;
  logic [23:0] r_sr;
  logic [1:0]  w_idx_n;
  logic [23:0] w_sr_n;
  logic        w_full;
  logic        w_take;

  // Next index/shift contents and the word strobe for this edge.
  always_comb begin
    w_take     = i_byte_vld && !i_clr;
    w_full     = w_take && (r_idx == 2'd3);
    w_sr_n     = w_take ? {r_sr[15:0], i_byte} : r_sr;
    w_idx_n    = w_take ? r_idx + 2'd1 : r_idx;
    o_word_vld = 1'b0;
    o_word     = ZeroWord;
    if (w_full) begin
      o_word_vld = 1'b1;
      o_word     = {r_sr, i_byte};
    end else if (i_flush && !i_clr && (w_idx_n != 2'd0)) begin
      o_word_vld = 1'b1;
      o_word     = pad_word(w_sr_n, w_idx_n);
    end
  end

  // Byte index: cleared on restart and at end of image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_idx <= 2'd0;
    else if (i_clr || i_flush) r_idx <= 2'd0;
    else                      r_idx <= w_idx_n;
  end

  // Shift register holds data only; stale bytes are never read past r_idx.
  always_ff @(posedge clk) begin
    if (w_take) r_sr <= w_sr_n;
  end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: combinational fetch port backed by a word
// array that is filled from a byte-stream loader while the core is held in
// reset. Optional macro INST_ALIGN_CHECK_EN adds misalign_o and blanks
// misaligned fetches.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int AW    = 10,
  parameter int CNT_W = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_mem_responder_if.slave    bus
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  imr_state_e       r_state;
  imr_state_e       w_state_n;
  logic [CNT_W-1:0] r_wptr;
  logic             r_err;
  inst_t            r_mem [DEPTH];

  logic             w_in_load;
  logic             w_accept;
  logic             w_flush;
  logic             w_word_vld;
  inst_t            w_word;
  logic [AW-1:0]    w_rd_idx;
  logic             w_misalign;
  logic             w_unused;

  assign w_in_load = (r_state == IMR_LOAD);
  assign w_accept  = w_in_load && bus.ld_valid_i;
  assign w_flush   = w_in_load && bus.ld_done_i && !bus.ld_start_i;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IMR_HOLD;
    else      r_state <= w_state_n;
  end

  // Next state and hold/ready decode; start beats done.
  always_comb begin
    w_state_n      = r_state;
    bus.cpu_hold_o = 1'b1;
    bus.ld_ready_o = 1'b0;
    case (r_state)
      IMR_HOLD: begin
        if (bus.ld_start_i) w_state_n = IMR_LOAD;
      end
      IMR_LOAD: begin
        bus.ld_ready_o = 1'b1;
        if (bus.ld_start_i)     w_state_n = IMR_LOAD;
        else if (bus.ld_done_i) w_state_n = IMR_RUN;
      end
      IMR_RUN: begin
        bus.cpu_hold_o = 1'b0;
        if (bus.ld_start_i) w_state_n = IMR_LOAD;
      end
      default: w_state_n = IMR_HOLD;
    endcase
  end

  inst_mem_responder_ld_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (bus.ld_start_i),
    .i_byte_vld (w_accept),
    .i_byte     (bus.ld_byte_i),
    .i_flush    (w_flush),
    .o_word_vld (w_word_vld),
    .o_word     (w_word)
  );

  // Write pointer doubles as the word count; saturates at depth and flags overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_err  <= 1'b0;
    end else if (bus.ld_start_i) begin
      r_wptr <= '0;
      r_err  <= 1'b0;
    end else if (w_word_vld) begin
      if (r_wptr == FULL_CNT) r_err  <= 1'b1;
      else                    r_wptr <= r_wptr + 1'b1;
    end
  end

  // Memory array is never reset; words past the end are dropped.
  always_ff @(posedge clk) begin
    if (w_word_vld && (r_wptr != FULL_CNT)) r_mem[r_wptr[AW-1:0]] <= w_word;
  end

  assign bus.ld_count_o = r_wptr;
  assign bus.ld_err_o   = r_err;

  assign w_rd_idx = bus.rom_addr_i[AW+1:2];
  assign w_unused = ^{bus.rom_addr_i[INST_ADDR_W-1:AW+2], bus.rom_addr_i[1:0]};

`ifdef INST_ALIGN_CHECK_EN
  assign w_misalign = bus.rom_ce_i && (r_state == IMR_RUN) && (bus.rom_addr_i[1:0] != 2'b00);
  assign bus.misalign_o = w_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  // Combinational fetch so the instruction is ready at the same edge as the PC.
  always_comb begin
    bus.rom_data_o = ZeroWord;
    if (bus.rom_ce_i && (r_state == IMR_RUN) && !w_misalign)
      bus.rom_data_o = r_mem[w_rd_idx];
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;
  import inst_mem_responder_pkg::*;

  localparam int AW    = 2;
  localparam int CNT_W = AW + 1;
`ifdef INST_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  inst_mem_responder_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

  inst_mem_responder #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_mis;
  } rd_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.ld_start_i = 1'b1;
    tick();
    bus.ld_start_i = 1'b0;
  endtask

  task automatic pulse_done();
    bus.ld_done_i = 1'b1;
    tick();
    bus.ld_done_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.ld_valid_i = 1'b1;
    bus.ld_byte_i  = b;
    tick();
    bus.ld_valid_i = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = addr;
    #1;
    chk(nm, bus.rom_data_o, exp);
  endtask

  rd_vec_t rv [6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst            = 1'b0;
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = 32'h0;
    bus.ld_start_i = 1'b0;
    bus.ld_valid_i = 1'b0;
    bus.ld_byte_i  = 8'h00;
    bus.ld_done_i  = 1'b0;

    rv[0] = '{"rd_a0",    1'b1, 32'h0000_0000, 32'h3401_0005, 1'b0};
    rv[1] = '{"rd_a4",    1'b1, 32'h0000_0004, 32'h2402_0007, 1'b0};
    rv[2] = '{"rd_ce0",   1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0};
    rv[3] = '{"rd_a7",    1'b1, 32'h0000_0007, ALIGN ? 32'h0 : 32'h2402_0007, ALIGN};
    rv[4] = '{"rd_wrap",  1'b1, 32'h0000_0014, 32'h2402_0007, 1'b0};
    rv[5] = '{"rd_hiign", 1'b1, 32'h8000_1000, 32'h3401_0005, 1'b0};

    // Reset state with fetch enabled
    tick();
    tick();
    chk("rst_hold",  bus.cpu_hold_o, 1);
    chk("rst_ready", bus.ld_ready_o, 0);
    chk("rst_data",  bus.rom_data_o, 0);
    chk("rst_count", bus.ld_count_o, 0);
    chk("rst_err",   bus.ld_err_o,   0);
    rst = 1'b1;
    tick();
    chk("hold_after_rst", bus.cpu_hold_o, 1);

    // Basic load
    pulse_start();
    chk("load_ready", bus.ld_ready_o, 1);
    chk("load_hold",  bus.cpu_hold_o, 1);
    chk("load_data0", bus.rom_data_o, 0);
    foreach (rv[i]) begin end
    send_byte(8'h34); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    chk("cnt_1word", bus.ld_count_o, 1);
    send_byte(8'h24); send_byte(8'h02); send_byte(8'h00); send_byte(8'h07);
    pulse_done();
    chk("basic_hold", bus.cpu_hold_o, 0);
    chk("basic_ready", bus.ld_ready_o, 0);
    chk("basic_count", bus.ld_count_o, 2);
    for (int i = 0; i < 6; i++) begin
      bus.rom_ce_i   = rv[i].ce;
      bus.rom_addr_i = rv[i].addr;
      #1;
      chk(rv[i].name, bus.rom_data_o, rv[i].exp_data);
`ifdef INST_ALIGN_CHECK_EN
      chk({rv[i].name, "_mis"}, bus.misalign_o, rv[i].exp_mis);
`endif
    end
`ifdef INST_ALIGN_CHECK_EN
    rd("mis_a6", 32'h6, 32'h0);
    chk("mis_a6_flag", bus.misalign_o, 1);
`endif

    // Ignored inputs while running
    bus.ld_valid_i = 1'b1; bus.ld_byte_i = 8'hFF;
    bus.ld_done_i  = 1'b1;
    tick(); tick(); tick(); tick();
    bus.ld_valid_i = 1'b0; bus.ld_done_i = 1'b0;
    chk("run_ign_count", bus.ld_count_o, 2);
    chk("run_ign_hold",  bus.cpu_hold_o, 0);
    rd("run_ign_mem", 32'h0, 32'h3401_0005);

    // Partial word padded on done
    pulse_start();
    chk("restart_count", bus.ld_count_o, 0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'hEE);
    pulse_done();
    chk("part_count", bus.ld_count_o, 2);
    rd("part_w0", 32'h0, 32'hAABB_CCDD);
    rd("part_w1", 32'h4, 32'hEE00_0000);

    // Byte accepted together with done
    pulse_start();
    send_byte(8'h11); send_byte(8'h22);
    bus.ld_valid_i = 1'b1; bus.ld_byte_i = 8'h33; bus.ld_done_i = 1'b1;
    tick();
    bus.ld_valid_i = 1'b0; bus.ld_done_i = 1'b0;
    chk("bd_count", bus.ld_count_o, 1);
    chk("bd_hold",  bus.cpu_hold_o, 0);
    rd("bd_w0", 32'h0, 32'h1122_3300);

    // Overflow: 17 words into a 4-word memory
    pulse_start();
    for (int k = 0; k < 17; k++)
      for (int j = 0; j < 4; j++) send_byte(8'(4 * k + j));
    chk("ovf_err_live", bus.ld_err_o, 1);
    pulse_done();
    chk("ovf_count", bus.ld_count_o, 4);
    chk("ovf_err",   bus.ld_err_o,   1);
    for (int k = 0; k < 4; k++)
      rd("ovf_mem", 32'(4 * k),
         {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)});
    pulse_start();
    chk("ovf_clr_err",   bus.ld_err_o,   0);
    chk("ovf_clr_count", bus.ld_count_o, 0);

    // Async reset mid-load, then start+done together
    for (int j = 1; j <= 6; j++) send_byte(8'(j));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_hold",  bus.cpu_hold_o, 1);
    chk("mid_rst_ready", bus.ld_ready_o, 0);
    chk("mid_rst_count", bus.ld_count_o, 0);
    tick();
    rst = 1'b1;
    tick();
    bus.ld_start_i = 1'b1; bus.ld_done_i = 1'b1;
    tick();
    bus.ld_start_i = 1'b0; bus.ld_done_i = 1'b0;
    chk("sd_ready", bus.ld_ready_o, 1);
    chk("sd_hold",  bus.cpu_hold_o, 1);
    pulse_done();
    chk("sd_run_hold", bus.cpu_hold_o, 0);
    chk("sd_count",    bus.ld_count_o, 0);
    rd("mid_keep_w0", 32'h0, 32'h0102_0304);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
